// File: rtl/results_pkg.sv
// Shared types and constants for the results readback path.
// State encoding, component tags and word geometry live here so that the top
// level and the output register agree on them.
package results_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [1:0] COMP_X   = 2'd0;
  localparam logic [1:0] COMP_Y   = 2'd1;
  localparam logic [1:0] COMP_Z   = 2'd2;
  localparam logic [1:0] COMP_SUM = 2'd3;

  localparam int WORD_BYTES      = 32'd4;
  localparam int WORDS_PER_POINT = 32'd3;

  // Rolling X -> Y -> Z -> X component tag, so no modulo-3 divider is needed.
  function automatic logic [1:0] comp_advance(input logic [1:0] comp);
    logic [1:0] nxt;
    case (comp)
      COMP_X:  nxt = COMP_Y;
      COMP_Y:  nxt = COMP_Z;
      default: nxt = COMP_X;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/results_out_reg.sv
// Output holding register for the result stream.
// A load captures a beat and raises valid; the beat is held untouched while
// the consumer stalls and is cleared once it has been accepted. A load in the
// same cycle as an accept wins, which lets a follow-on beat be queued directly.
module results_out_reg
  import results_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_comp,
  input  logic        load_last,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [1:0]  m_comp,
  output logic        m_last,
  output logic        m_valid,
  output logic        accept
);

  assign accept = m_valid & m_ready;

  // Hold the presented beat: load has priority, then clear-on-accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_data  <= 32'd0;
      m_comp  <= COMP_X;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_comp  <= load_comp;
      m_last  <= load_last;
      m_valid <= 1'b1;
    end else if (accept) begin
      m_data  <= 32'd0;
      m_comp  <= COMP_X;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/results_readback.sv
// Results readback: after the save stage signals completion, walk the results
// BRAM and stream every stored X/Y/Z word over a valid/ready interface.
// Optional build macro: RESULTS_CHECKSUM_EN appends one beat carrying the
// mod-2^32 sum of all streamed words (tag 3, carries m_last).
module results_readback
  import results_pkg::*;
#(
  parameter int ADDR_W       = 32'd32,
  parameter int BASE_ADDR    = 32'd4,
  parameter int READ_LATENCY = 32'd1,
  parameter int MAX_POINTS   = 32'd4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              save_done,
  input  logic [31:0]       num_points,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  input  logic [31:0]       bram_dout,
  output logic [31:0]       m_data,
  output logic [1:0]        m_comp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  // Word counter only has to reach 3 * MAX_POINTS.
  localparam int          CNT_W    = $clog2(WORDS_PER_POINT * MAX_POINTS + 32'd1);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 32'd1);
  localparam logic [31:0] MAX_N    = 32'(MAX_POINTS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WORD_BYTES);

  state_t            state_r, state_nxt;
  logic              save_done_prev_r;
  logic [CNT_W-1:0]  total_r, total_nxt;
  logic [CNT_W-1:0]  word_cnt_r, word_cnt_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [1:0]        comp_r, comp_nxt;
  logic [1:0]        lat_cnt_r, lat_cnt_nxt;
  logic [ADDR_W-1:0] bram_addr_r;
  logic              bram_en_r;
  logic              busy_r;
  logic              done_r;
  logic              start;
  logic              final_word;
  logic [31:0]       n_clamp;
  logic              ld;
  logic [31:0]       ld_data;
  logic [1:0]        ld_comp;
  logic              ld_last;
  logic              accept;
`ifdef RESULTS_CHECKSUM_EN
  logic [31:0]       sum_r, sum_nxt;
  logic              sum_phase_r, sum_phase_nxt;
`endif

  assign start      = save_done & ~save_done_prev_r;
  assign n_clamp    = (num_points > MAX_N) ? MAX_N : num_points;
  assign final_word = (word_cnt_r == (total_r - CNT_W'(1)));

  assign bram_addr = bram_addr_r;
  assign bram_en   = bram_en_r;
  assign bram_we   = 4'b0000;
  assign busy      = busy_r;
  assign done      = done_r;

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, counter updates and output-register load control.
  always_comb begin
    state_nxt    = state_r;
    total_nxt    = total_r;
    word_cnt_nxt = word_cnt_r;
    addr_nxt     = addr_r;
    comp_nxt     = comp_r;
    lat_cnt_nxt  = 2'd0;
    ld           = 1'b0;
    ld_data      = bram_dout;
    ld_comp      = comp_r;
    ld_last      = 1'b0;
`ifdef RESULTS_CHECKSUM_EN
    sum_nxt       = sum_r;
    sum_phase_nxt = sum_phase_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          total_nxt    = CNT_W'(n_clamp * 32'(WORDS_PER_POINT));
          word_cnt_nxt = '0;
          addr_nxt     = BASE;
          comp_nxt     = COMP_X;
`ifdef RESULTS_CHECKSUM_EN
          sum_nxt       = 32'd0;
          sum_phase_nxt = 1'b0;
`endif
          if (n_clamp == 32'd0) begin
`ifdef RESULTS_CHECKSUM_EN
            // Empty result set still reports a (zero) checksum beat.
            ld            = 1'b1;
            ld_data       = 32'd0;
            ld_comp       = COMP_SUM;
            ld_last       = 1'b1;
            sum_phase_nxt = 1'b1;
            state_nxt     = PRESENT;
`else
            state_nxt = FINISH;
`endif
          end else begin
            state_nxt = ISSUE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          ld = 1'b1;
`ifdef RESULTS_CHECKSUM_EN
          sum_nxt = sum_r + bram_dout;
`else
          ld_last = final_word;
`endif
          state_nxt = PRESENT;
        end else begin
          lat_cnt_nxt = lat_cnt_r + 2'd1;
          state_nxt   = WAIT;
        end
      end
      PRESENT: begin
        if (accept) begin
          word_cnt_nxt = word_cnt_r + CNT_W'(1);
          addr_nxt     = addr_r + STEP;
          comp_nxt     = comp_advance(comp_r);
`ifdef RESULTS_CHECKSUM_EN
          if (sum_phase_r) begin
            state_nxt = FINISH;
          end else if (final_word) begin
            // Sum already includes the last Z word, loaded during WAIT.
            ld            = 1'b1;
            ld_data       = sum_r;
            ld_comp       = COMP_SUM;
            ld_last       = 1'b1;
            sum_phase_nxt = 1'b1;
            state_nxt     = PRESENT;
          end else begin
            state_nxt = ISSUE;
          end
`else
          if (final_word) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = ISSUE;
          end
`endif
        end else begin
          state_nxt = PRESENT;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath counters and save_done edge history.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      save_done_prev_r <= 1'b0;
      total_r          <= '0;
      word_cnt_r       <= '0;
      addr_r           <= '0;
      comp_r           <= COMP_X;
      lat_cnt_r        <= 2'd0;
    end else begin
      save_done_prev_r <= save_done;
      total_r          <= total_nxt;
      word_cnt_r       <= word_cnt_nxt;
      addr_r           <= addr_nxt;
      comp_r           <= comp_nxt;
      lat_cnt_r        <= lat_cnt_nxt;
    end
  end

`ifdef RESULTS_CHECKSUM_EN
  // Running checksum and "checksum beat queued" flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sum_r       <= 32'd0;
      sum_phase_r <= 1'b0;
    end else begin
      sum_r       <= sum_nxt;
      sum_phase_r <= sum_phase_nxt;
    end
  end
`endif

  // Registered BRAM port and status outputs, derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bram_en_r   <= 1'b0;
      bram_addr_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      bram_en_r <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE) begin
        bram_addr_r <= addr_nxt;
      end
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_nxt == FINISH);
    end
  end

  results_out_reg u_out_reg (
    .clock     (clock),
    .resetn    (resetn),
    .load      (ld),
    .load_data (ld_data),
    .load_comp (ld_comp),
    .load_last (ld_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_comp    (m_comp),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .accept    (accept)
  );

endmodule

// File: tb/tb_results_readback.sv
// Testbench for results_readback: a BRAM model, a transfer-level expectation
// queue built from the stored words, and one per-cycle compare process.
module tb_results_readback;

`ifdef RESULTS_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
    logic        l;
  } beat_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        save_done = 1'b0;
  logic [31:0] num_points = 32'd0;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_dout = 32'd0;
  logic [31:0] m_data;
  logic [1:0]  m_comp;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:63];
  beat_t       exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] log_data[$];
  logic [1:0]  log_comp[$];
  logic        log_last[$];
  logic [31:0] log_addr[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  int beats = 0;
  int stalls = 0;
  int ready_mode = 0;
  int ridx = 0;
  logic [3:0] ready_pat = 4'b1001;

  logic        stalled = 1'b0;
  logic [31:0] hold_data;
  logic [1:0]  hold_comp;
  logic        hold_last;

  results_readback dut (
    .clock      (clock),
    .resetn     (resetn),
    .save_done  (save_done),
    .num_points (num_points),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_dout  (bram_dout),
    .m_data     (m_data),
    .m_comp     (m_comp),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  initial forever #5 clock = ~clock;

  // One-cycle-latency BRAM read port.
  always @(posedge clock) begin
    if (bram_en) bram_dout <= mem[(bram_addr >> 2) % 64];
  end

  // Consumer ready: constant 1, or the repeating 1,0,0,1 stall pattern.
  initial forever begin
    @(posedge clock);
    #1;
    if (ready_mode == 1) begin
      m_ready = ready_pat[ridx % 4];
      ridx++;
    end else begin
      m_ready = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%0h required=nothing at %0t", name, act, $time);
  endtask

  // Expected transfer: words from address 4 upward, tags k mod 3, last on the
  // final Z (or on the checksum beat when that feature is built in).
  task automatic plan_transfer(input int n);
    int nc;
    logic [31:0] sum;
    beat_t b;
    nc = (n > 4096) ? 4096 : n;
    sum = 32'd0;
    for (int k = 0; k < 3 * nc; k++) begin
      b.d = mem[1 + k];
      b.c = 2'(k % 3);
      b.l = (k == 3 * nc - 1) && !CS;
      sum = sum + b.d;
      exp_q.push_back(b);
      exp_addr_q.push_back(32'(4 + 4 * k));
    end
    if (CS) begin
      b.d = sum;
      b.c = 2'd3;
      b.l = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_comp.delete();
    log_last.delete();
    log_addr.delete();
  endtask

  task automatic wait_done(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("done_timeout", 64'(bound));
    cycles(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  task automatic check_drained(input string tag, input int d0);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_addr_left"}, exp_addr_q.size(), 0);
    check({tag, "_done_count"}, done_count, d0 + 1);
  endtask

  // Per-cycle compare against the expectation queues.
  always @(negedge clock) begin
    if (resetn) begin
      if (bram_en) begin
        check("bram_we", bram_we, 0);
        log_addr.push_back(bram_addr);
        if (exp_addr_q.size() == 0) flag("bram_addr_extra", bram_addr);
        else check("bram_addr", bram_addr, exp_addr_q.pop_front());
      end
      if (stalled) begin
        stalls++;
        check("stall_hold", {m_valid, m_last, m_comp, m_data},
              {1'b1, hold_last, hold_comp, hold_data});
      end
      if (m_valid && m_ready) begin
        beat_t e;
        beats++;
        log_data.push_back(m_data);
        log_comp.push_back(m_comp);
        log_last.push_back(m_last);
        if (exp_q.size() == 0) begin
          flag("beat_extra", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.d);
          check("m_comp", m_comp, e.c);
          check("m_last", m_last, e.l);
        end
      end
      if (done) begin
        done_count++;
        check("busy_on_done", busy, 1);
      end
      stalled = m_valid && !m_ready;
      hold_data = m_data;
      hold_comp = m_comp;
      hold_last = m_last;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[1] = 32'h11; mem[2] = 32'h12; mem[3] = 32'h13;
    mem[4] = 32'h21; mem[5] = 32'h22; mem[6] = 32'h23;

    // Reset state.
    resetn = 1'b0;
    cycles(3);
    check_idle_outputs("reset");
    check("reset_bram_we", bram_we, 0);
    resetn = 1'b1;
    cycles(2);
    check_idle_outputs("post_reset");

    // n = 2, continuous ready.
    clear_logs();
    d0 = done_count;
    num_points = 32'd2;
    plan_transfer(2);
    save_done = 1'b1;
    check("busy_before_start", busy, 0);
    cycles(1);
    check("busy_after_start", busy, 1);
    check("bram_en_first", bram_en, 1);
    wait_done(300);
    cycles(2);
    check_drained("t1", d0);
    check("t1_first_data", log_data[0], 32'h11);
    check("t1_beat5_data", log_data[4], 32'h22);
    check("t1_beat5_comp", log_comp[4], 2'd1);
    check("t1_beat6_comp", log_comp[5], 2'd2);
    check("t1_first_addr", log_addr[0], 32'd4);
    check("t1_last_addr", log_addr[5], 32'd24);
`ifdef RESULTS_CHECKSUM_EN
    check("t1_beats", log_data.size(), 7);
    check("t1_sum", log_data[6], 32'h9c);
    check("t1_last_on_sum", log_last[6], 1);
`else
    check("t1_beats", log_data.size(), 6);
    check("t1_last_on_z", log_last[5], 1);
    check("t1_no_last_early", log_last[4], 0);
`endif
    check("t1_idle_busy", busy, 0);
    save_done = 1'b0;
    cycles(3);

    // Same data, ready toggling 1,0,0,1.
    clear_logs();
    d0 = done_count;
    ridx = 0;
    ready_mode = 1;
    plan_transfer(2);
    save_done = 1'b1;
    wait_done(400);
    cycles(2);
    ready_mode = 0;
    check_drained("t2", d0);
    check("t2_stalls_seen", (stalls > 0), 1);
    check("t2_beats", log_data.size(), CS ? 7 : 6);
    save_done = 1'b0;
    cycles(3);

    // n = 0: no data beats.
    clear_logs();
    d0 = done_count;
    num_points = 32'd0;
    plan_transfer(0);
    save_done = 1'b1;
    wait_done(50);
    cycles(2);
    check_drained("t3", d0);
    check("t3_no_reads", log_addr.size(), 0);
`ifdef RESULTS_CHECKSUM_EN
    check("t3_beats", log_data.size(), 1);
    check("t3_sum_data", log_data[0], 32'd0);
    check("t3_sum_comp", log_comp[0], 2'd3);
    check("t3_sum_last", log_last[0], 1);
`else
    check("t3_beats", log_data.size(), 0);
`endif
    save_done = 1'b0;
    cycles(3);

    // Second edge mid-transfer plus long high level: exactly one transfer.
    clear_logs();
    d0 = done_count;
    b0 = beats;
    num_points = 32'd2;
    plan_transfer(2);
    save_done = 1'b1;
    cycles(5);
    save_done = 1'b0;
    cycles(1);
    save_done = 1'b1;
    wait_done(300);
    cycles(100);
    check_drained("t4", d0);
    check("t4_beats", beats - b0, CS ? 7 : 6);
    save_done = 1'b0;
    cycles(3);

    // Reset after beat 3, then restart.
    clear_logs();
    d0 = done_count;
    b0 = beats;
    plan_transfer(2);
    save_done = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (beats >= b0 + 3) break;
    end
    check("t5_reached_beat3", beats - b0, 3);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    save_done = 1'b0;
    #1;
    check_idle_outputs("t5_abort");
    exp_q.delete();
    exp_addr_q.delete();
    cycles(3);
    resetn = 1'b1;
    cycles(2);
    check("t5_no_done", done_count, d0);
    clear_logs();
    plan_transfer(2);
    save_done = 1'b1;
    wait_done(300);
    cycles(2);
    check_drained("t5", d0);
    check("t5_restart_addr", log_addr[0], 32'd4);
    check("t5_restart_data", log_data[0], 32'h11);
    save_done = 1'b0;
    cycles(3);

    // n = 1 with wrapping checksum words.
    mem[1] = 32'hFFFFFFFF; mem[2] = 32'h2; mem[3] = 32'h3;
    clear_logs();
    d0 = done_count;
    num_points = 32'd1;
    plan_transfer(1);
    save_done = 1'b1;
    wait_done(300);
    cycles(2);
    check_drained("t6", d0);
    check("t6_first_data", log_data[0], 32'hFFFFFFFF);
`ifdef RESULTS_CHECKSUM_EN
    check("t6_beats", log_data.size(), 4);
    check("t6_sum_data", log_data[3], 32'h00000004);
    check("t6_sum_comp", log_comp[3], 2'd3);
    check("t6_sum_last", log_last[3], 1);
`else
    check("t6_beats", log_data.size(), 3);
    check("t6_last_on_z", log_last[2], 1);
`endif
    save_done = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
